tensor_smem_port: RTL
=====================

Name: tensor_smem_port

Overview:
- Adapter between one tensor core operand request port (A or B) and one shared-memory bank-group port.
- Takes tensor core requests (address + source tag), turns them into SMEM word requests carrying an internal slot tag, and accepts SMEM responses that may arrive out of order.
- Returns responses to the tensor core in issue order.
- Two instances per core: one for operand A, one for operand B.

Parameters:
- DEPTH, 4, max outstanding requests / reorder slots (power of 2, >=2)
- TAG_W, 4, tensor core source-tag width
- ADDR_W, 32, tensor core byte-address width (XLEN)
- DATA_W, 256, response data width (NUM_THREADS x 32)
- SMEM_BASE, 32'hFF00_0000, byte base of shared memory in the address map
- SMEM_ADDR_W, 14, SMEM byte-address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tc_req_valid  in  1  tensor core request valid
- tc_req_ready  out  1  request accepted
- tc_req_addr  in  ADDR_W  byte address
- tc_req_tag  in  TAG_W  source tag, echoed on response
- tc_rsp_valid  out  1  in-order response valid
- tc_rsp_ready  in  1  tensor core accepts response
- tc_rsp_tag  out  TAG_W  echoed source tag
- tc_rsp_data  out  DATA_W  response data
- mem_req_valid  out  1  SMEM request valid
- mem_req_ready  in  1  SMEM accepts request
- mem_req_addr  out  WADDR_W  word address, WADDR_W = SMEM_ADDR_W - log2(DATA_W/8)
- mem_req_tag  out  log2(DEPTH)  slot index
- mem_rsp_valid  in  1  SMEM response (no backpressure)
- mem_rsp_tag  in  log2(DEPTH)  slot index of response
- mem_rsp_data  in  DATA_W  response data
- busy  out  1  any slot allocated
- err  out  1  sticky error flag

Behaviour:
- Reset (async assert): head = tail = count = 0; all slot pending/done bits = 0; tc_rsp_valid = 0; err = 0; busy = 0; tc_rsp_data/tag = 0. Deassertion is used synchronously.
- Full = (count == DEPTH).
- Request path is combinational pass-through:
  - mem_req_valid = tc_req_valid && !full
  - tc_req_ready = mem_req_ready && !full
  - mem_req_tag = tail
- Address translation: mem_req_addr = (tc_req_addr - SMEM_BASE)[SMEM_ADDR_W-1 : log2(DATA_W/8)]. Low offset bits are ignored.
- Out-of-window check: if a fired request has (tc_req_addr - SMEM_BASE) >= 2^SMEM_ADDR_W, set err. The request is still issued.
- Issue fire (tc_req_valid && tc_req_ready): slot[tail].tag <= tc_req_tag, pending[tail] <= 1, tail <= tail+1 (wraps mod DEPTH), count++.
- mem_rsp_valid handling:
  - If pending[mem_rsp_tag] && !done[mem_rsp_tag]: store the data into that slot and set done.
  - Otherwise (stray or duplicate): drop the data and set err.
- Retire:
  - tc_rsp_valid is registered: 1 when done[head] is 1. Data and tag come from slot[head].
  - Minimum latency: mem_rsp at cycle t for the head slot gives tc_rsp_valid at t+1.
  - Retire fire (tc_rsp_valid && tc_rsp_ready): clear pending/done[head], head++ (wraps), count--.
  - tc_rsp_valid, tc_rsp_data and tc_rsp_tag hold stable while tc_rsp_ready = 0.
- Simultaneous events:
  - Issue and retire in the same cycle: count unchanged.
  - When full, no issue even if a retire happens that cycle (ready does not depend on tc_rsp_ready).
  - mem_rsp for slot X in the same cycle that X is retired cannot occur, since retire requires done already set; if it does occur it is treated as a duplicate and sets err.
- busy = (count != 0), registered.
- err is sticky until reset.
- Reset mid-operation: all in-flight slots are discarded. SMEM responses after reset that target non-pending slots set err (expected; the bench ignores err across reset).

Decomposition:
- Shared package: SMEM_BASE, SMEM_ADDR_W, DATA_W derived from NUM_THREADS x XLEN, slot-tag width function, and a tc-bus request/response struct typedef.
- One sub-module, tensor_smem_rob: slot storage (tag, data, pending, done) with head/tail/count and alloc/fill/retire ports.
- The top level holds address translation, the handshake glue and err.

Test Plan:
- Single request: addr = SMEM_BASE+0x40, tag = 3; mem_rsp at t+2 with data D -> mem_req_addr = 2; tc_rsp_valid at t+3 with tag 3, data D; busy back to 0 after the retire cycle.
- Out-of-order: issue tags 1, 2, 3, 4 to slots 0-3; SMEM returns slots 3, 1, 0, 2 -> tc responses in tag order 1, 2, 3, 4; tc_req_ready = 0 while count = 4.
- Backpressure: tc_rsp_ready = 0 for 5 cycles with the head done -> valid/data/tag stable; issue stalls at full; retire and issue in the same cycle leaves count at DEPTH-1 then refills.
- Wrap-around: 3xDEPTH back-to-back requests with 1-cycle in-order SMEM latency and tc_rsp_ready = 1 -> all 12 returned in order; pointers wrap; err = 0.
- Errors: addr = SMEM_BASE + 0x4000 -> err = 1 and the request is still issued; separately, mem_rsp to a non-pending slot 2 -> err = 1 and no tc_rsp.
- Async reset asserted mid-flight with 3 outstanding -> outputs reset immediately; after release, a new request uses slot 0 and completes normally.

Source files
------------

// File: rtl/tensor_smem_port_pkg.sv
// Shared constants, slot-tag sizing and tensor-core bus payload types for the
// tensor core <-> shared-memory operand port.
package tensor_smem_port_pkg;

   localparam int unsigned NUM_THREADS     = 8;
   localparam int unsigned XLEN            = 32;
   localparam int unsigned DEF_DATA_W      = NUM_THREADS * XLEN;
   localparam int unsigned DEF_TAG_W       = 4;
   localparam int unsigned DEF_DEPTH       = 4;
   localparam int unsigned DEF_SMEM_ADDR_W = 14;
   localparam logic [XLEN-1:0] DEF_SMEM_BASE = 32'hFF00_0000;

   function automatic int unsigned slot_tag_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic [XLEN-1:0]      addr;
      logic [DEF_TAG_W-1:0] tag;
   } tc_req_t;

   typedef struct packed {
      logic [DEF_TAG_W-1:0]  tag;
      logic [DEF_DATA_W-1:0] data;
   } tc_rsp_t;

endpackage

// File: rtl/tensor_smem_port_if.sv
// Tensor-core request/response and SMEM request/response channels of one
// operand port; slave is the adapter side, master is the environment side.
interface tensor_smem_port_if
   import tensor_smem_port_pkg::*;
#(
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned TAG_W       = DEF_TAG_W,
   parameter int unsigned ADDR_W      = XLEN,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned SMEM_ADDR_W = DEF_SMEM_ADDR_W,
   localparam int unsigned WADDR_W    = SMEM_ADDR_W - $clog2(DATA_W / 8),
   localparam int unsigned SW         = slot_tag_w(DEPTH)
);

   logic              tc_req_valid;
   logic              tc_req_ready;
   logic [ADDR_W-1:0] tc_req_addr;
   logic [TAG_W-1:0]  tc_req_tag;
   logic              tc_rsp_valid;
   logic              tc_rsp_ready;
   logic [TAG_W-1:0]  tc_rsp_tag;
   logic [DATA_W-1:0] tc_rsp_data;

   logic               mem_req_valid;
   logic               mem_req_ready;
   logic [WADDR_W-1:0] mem_req_addr;
   logic [SW-1:0]      mem_req_tag;
   logic               mem_rsp_valid;
   logic [SW-1:0]      mem_rsp_tag;
   logic [DATA_W-1:0]  mem_rsp_data;

   modport slave (
      input  tc_req_valid, tc_req_addr, tc_req_tag, tc_rsp_ready,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
      output tc_req_ready, tc_rsp_valid, tc_rsp_tag, tc_rsp_data,
      output mem_req_valid, mem_req_addr, mem_req_tag
   );

   modport master (
      output tc_req_valid, tc_req_addr, tc_req_tag, tc_rsp_ready,
      output mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
      input  tc_req_ready, tc_rsp_valid, tc_rsp_tag, tc_rsp_data,
      input  mem_req_valid, mem_req_addr, mem_req_tag
   );

endinterface

// File: rtl/tensor_smem_port_rob.sv
// Reorder buffer: slots allocated in issue order, filled out of order by slot
// index, retired in order from the head.
module tensor_smem_rob
   import tensor_smem_port_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned TAG_W  = DEF_TAG_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   localparam int unsigned SW    = slot_tag_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_alloc,
   input  logic [TAG_W-1:0]  i_alloc_tag,
   input  logic              i_fill,
   input  logic [SW-1:0]     i_fill_slot,
   input  logic [DATA_W-1:0] i_fill_data,
   input  logic              i_rsp_ready,
   output logic              o_full,
   output logic              o_busy,
   output logic [SW-1:0]     o_tail,
   output logic              o_fill_err,
   output logic              o_rsp_valid,
   output logic [TAG_W-1:0]  o_rsp_tag,
   output logic [DATA_W-1:0] o_rsp_data
);

   localparam logic [SW:0]   CNT_ONE  = 1;
   localparam logic [SW-1:0] PTR_ONE  = 1;
   localparam logic [SW:0]   FULL_CNT = (SW + 1)'(DEPTH);

   logic [SW-1:0]     r_head;
   logic [SW-1:0]     r_tail;
   logic [SW:0]       r_count;
   logic              r_busy;
   logic [DEPTH-1:0]  r_pending;
   logic [DEPTH-1:0]  r_done;
   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   logic        w_fill_ok;
   logic        w_retire;
   logic [SW:0] w_count_nxt;

   assign w_fill_ok  = r_pending[i_fill_slot] && !r_done[i_fill_slot];
   assign w_retire   = o_rsp_valid && i_rsp_ready;
   assign o_fill_err = i_fill && !w_fill_ok;

   assign o_full      = (r_count == FULL_CNT);
   assign o_busy      = r_busy;
   assign o_tail      = r_tail;
   assign o_rsp_valid = r_done[r_head];
   assign o_rsp_tag   = o_rsp_valid ? r_tag[r_head]  : '0;
   assign o_rsp_data  = o_rsp_valid ? r_data[r_head] : '0;

   always_comb begin
      w_count_nxt = r_count;
      case ({i_alloc, w_retire})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // A fill aimed at the head being retired is never w_fill_ok, so the
   // retire clear below cannot collide with a legitimate done set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_pending <= '0;
         r_done    <= '0;
      end else begin
         if (i_alloc) begin
            r_pending[r_tail] <= 1'b1;
            r_tail            <= r_tail + PTR_ONE;
         end
         if (i_fill && w_fill_ok) begin
            r_done[i_fill_slot] <= 1'b1;
         end
         if (w_retire) begin
            r_pending[r_head] <= 1'b0;
            r_done[r_head]    <= 1'b0;
            r_head            <= r_head + PTR_ONE;
         end
         r_count <= w_count_nxt;
         r_busy  <= (w_count_nxt != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (i_alloc) begin
         r_tag[r_tail] <= i_alloc_tag;
      end
      if (i_fill && w_fill_ok) begin
         r_data[i_fill_slot] <= i_fill_data;
      end
   end

endmodule

// File: rtl/tensor_smem_port.sv
// Tensor core operand port to shared-memory bank group: address translation,
// request/response handshake glue and sticky error flag around the ROB.
module tensor_smem_port
   import tensor_smem_port_pkg::*;
#(
   parameter int unsigned       DEPTH       = DEF_DEPTH,
   parameter int unsigned       TAG_W       = DEF_TAG_W,
   parameter int unsigned       ADDR_W      = XLEN,
   parameter int unsigned       DATA_W      = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] SMEM_BASE   = DEF_SMEM_BASE,
   parameter int unsigned       SMEM_ADDR_W = DEF_SMEM_ADDR_W
) (
   input  logic                 clk,
   input  logic                 reset,
   tensor_smem_port_if.slave    bus,
   output logic                 busy,
   output logic                 err
);

   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic [ADDR_W-1:0] w_offset;
   logic              w_oow;
   logic              w_full;
   logic              w_issue;
   logic              w_fill_err;
   logic              w_unused_ofs;
   logic              r_err;

   assign w_offset     = bus.tc_req_addr - SMEM_BASE;
   assign w_oow        = |w_offset[ADDR_W-1:SMEM_ADDR_W];
   assign w_unused_ofs = ^w_offset[OFF_W-1:0];

   assign bus.mem_req_valid = bus.tc_req_valid && !w_full;
   assign bus.tc_req_ready  = bus.mem_req_ready && !w_full;
   assign bus.mem_req_addr  = w_offset[SMEM_ADDR_W-1:OFF_W];
   assign w_issue           = bus.tc_req_valid && bus.tc_req_ready;

   tensor_smem_rob #(
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_rob (
      .clk         (clk),
      .reset       (reset),
      .i_alloc     (w_issue),
      .i_alloc_tag (bus.tc_req_tag),
      .i_fill      (bus.mem_rsp_valid),
      .i_fill_slot (bus.mem_rsp_tag),
      .i_fill_data (bus.mem_rsp_data),
      .i_rsp_ready (bus.tc_rsp_ready),
      .o_full      (w_full),
      .o_busy      (busy),
      .o_tail      (bus.mem_req_tag),
      .o_fill_err  (w_fill_err),
      .o_rsp_valid (bus.tc_rsp_valid),
      .o_rsp_tag   (bus.tc_rsp_tag),
      .o_rsp_data  (bus.tc_rsp_data)
   );

   // Out-of-window requests are still issued; they only raise the flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if ((w_issue && w_oow) || w_fill_err) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;

endmodule
